seg_disp: RTL and testbench
===========================

// Module: seg_disp
// PURPOSE
//  Hex-to-seven-segment decoder for the lab display path. Maps a 4-bit nibble s
//  (0x0-0xF) onto seven segment drives for a common-anode digit.
//  - seg is a combinational output for direct pin drive.
//  - seg_q is a registered copy for timing-clean or multiplexed use.
//  Sits between the digit-select/mux logic and the FPGA segment pins.
// PARAMETERS
//  ACTIVE_LOW  1  1: segment lit = 0 (common anode); 0: lit = 1 (bitwise invert of table)
// PORTS
//  clk    input   1  system clock; the single clock domain
//  reset  input   1  asynchronous, active-low reset
//  s      input   4  hex nibble to display
//  seg    output  7  combinational segment drive, bit order {g,f,e,d,c,b,a}
//  seg_q  output  7  registered segment drive, same encoding as seg
// BEHAVIOUR
//  Clocking and reset
//  - One clock (clk); reset is asynchronous and active-low.
//  - seg is purely combinational from s.
//    - Zero-cycle latency; settles within the same clock phase s changes in.
//    - Unaffected by reset or clk.
//  - seg_q updates to the decoded value of s on every rising clk edge.
//    - Latency: 1 cycle.
//  - reset low: seg_q asynchronously forced to all-off (7'b1111111 when ACTIVE_LOW=1).
//    - Stays all-off while reset is held low.
//    - First decoded value appears at the first rising clk edge after reset goes high.
//  Decode table (ACTIVE_LOW=1, seg={g,f,e,d,c,b,a})
//  - 0:1000000  1:1111001  2:0100100  3:0110000
//  - 4:0011001  5:0010010  6:0000010  7:1111000
//  - 8:0000000  9:0010000  A:0001000  b:0000011
//  - C:1000110  d:0100001  E:0000110  F:0001110
//  Boundary conditions
//  - All 16 codes are defined; there are no don't-care outputs.
//  - Full case coverage; no latches.
//  - s with X/Z: seg may go X. No other state is corrupted.
//  - s changing between clk edges: seg tracks immediately; seg_q samples only at posedge.
//  - Reset asserted mid-operation:
//    - seg_q goes all-off with no clock edge needed.
//    - seg keeps decoding s.
//  - ACTIVE_LOW=0: both outputs are the bitwise inverse of the table.
//    - seg_q reset value becomes 7'b0000000 (still all-off).
// TESTING
//  - Sweep s=0x0..0xF, check seg 1 ns after each change against the table:
//    s=0 -> 1000000; s=8 -> 0000000; s=F -> 0001110.
//  - Hold reset low, toggle clk with s=3 -> seg_q=1111111 and seg=0110000.
//  - Release reset with s=7 -> seg_q=1111111 until the next posedge, then 1111000.
//  - Change s 1 -> 2 mid-cycle -> seg=0100100 immediately;
//    seg_q stays 1111001 until the next posedge.
//  - Assert reset mid-stream with seg_q=0000000 (s=8), no clk edge -> seg_q=1111111 at once.
//  - ACTIVE_LOW=0, s=0 -> seg=0111111, seg_q=0111111 one cycle later.

Source files
------------

// File: rtl/seg_disp.sv
// Hex-to-seven-segment decoder for the lab display path.
// seg is the combinational drive for the pins.
// seg_q is the same value registered once, for timing-clean or multiplexed use.
// Segment bit order is {g,f,e,d,c,b,a}.
module seg_disp #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] s,
  output logic [6:0] seg,
  output logic [6:0] seg_q
);

  // Segment pattern for a dark digit in the selected polarity.
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'b1111111 : 7'b0000000;

  logic [6:0] seg_al;

  // Decode the nibble into the common-anode (lit = 0) pattern.
  always_comb begin
    seg_al = 7'b1111111;
    unique case (s)
      4'h0: seg_al = 7'b1000000;
      4'h1: seg_al = 7'b1111001;
      4'h2: seg_al = 7'b0100100;
      4'h3: seg_al = 7'b0110000;
      4'h4: seg_al = 7'b0011001;
      4'h5: seg_al = 7'b0010010;
      4'h6: seg_al = 7'b0000010;
      4'h7: seg_al = 7'b1111000;
      4'h8: seg_al = 7'b0000000;
      4'h9: seg_al = 7'b0010000;
      4'hA: seg_al = 7'b0001000;
      4'hB: seg_al = 7'b0000011;
      4'hC: seg_al = 7'b1000110;
      4'hD: seg_al = 7'b0100001;
      4'hE: seg_al = 7'b0000110;
      4'hF: seg_al = 7'b0001110;
      default: seg_al = 7'b1111111;
    endcase
  end

  // Apply the output polarity; the common-cathode build is a bitwise inversion.
  always_comb begin
    seg = ACTIVE_LOW ? seg_al : ~seg_al;
  end

  // Register the decoded value; reset blanks the digit without needing a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_q <= SEG_OFF;
    end else begin
      seg_q <= seg;
    end
  end

endmodule

// File: tb/tb_seg_disp.sv
// Self-checking bench for seg_disp, covering both output polarities.
module tb_seg_disp;

  logic       clk;
  logic       reset;
  logic [3:0] s;
  logic [6:0] seg_al, seg_q_al;
  logic [6:0] seg_ah, seg_q_ah;

  int n_cmp;
  int n_err;

  seg_disp #(.ACTIVE_LOW(1'b1)) u_dut_al (
    .clk   (clk),
    .reset (reset),
    .s     (s),
    .seg   (seg_al),
    .seg_q (seg_q_al)
  );

  seg_disp #(.ACTIVE_LOW(1'b0)) u_dut_ah (
    .clk   (clk),
    .reset (reset),
    .s     (s),
    .seg   (seg_ah),
    .seg_q (seg_q_ah)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the set of lit segments for each hex glyph, written as segment letters.
  string lit_segs [16] = '{
    "abcdef", "bc",     "abdeg",   "abcdg",
    "bcfg",   "acdfg",  "acdefg",  "abc",
    "abcdefg","abcdfg", "abcefg",  "cdefg",
    "adef",   "bcdeg",  "adefg",   "aefg"
  };

  function automatic logic [6:0] model(input logic [3:0] v, input bit active_low);
    logic [6:0] lit;
    string      str;
    byte        ch;
    lit = 7'b0000000;
    str = lit_segs[v];
    for (int i = 0; i < str.len(); i++) begin
      ch = str[i];
      lit[ch - 8'd97] = 1'b1;
    end
    return active_low ? ~lit : lit;
  endfunction

  // Model of the registered output: the value of s seen at the last clock edge
  // taken while out of reset, or a blank digit if none since reset.
  logic [3:0] s_at_edge;
  bit         edge_seen;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      edge_seen <= 1'b0;
    end else begin
      edge_seen <= 1'b1;
      s_at_edge <= s;
    end
  end

  function automatic logic [6:0] model_q(input bit active_low);
    if (!edge_seen) return active_low ? 7'b1111111 : 7'b0000000;
    return model(s_at_edge, active_low);
  endfunction

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("seg_al",   seg_al,   model(s, 1'b1));
    chk("seg_ah",   seg_ah,   model(s, 1'b0));
    chk("seg_q_al", seg_q_al, model_q(1'b1));
    chk("seg_q_ah", seg_q_ah, model_q(1'b0));
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    s     = 4'h3;

    // Reset held with the clock running: register stays blank, decoder live.
    repeat (3) @(posedge clk);
    #2;
    chk("rst_hold_seg",   seg_al,   7'b0110000);
    chk("rst_hold_seg_q", seg_q_al, 7'b1111111);
    chk("rst_hold_q_ah",  seg_q_ah, 7'b0000000);

    // Release reset with s=7: blank until the next edge, then the 7 glyph.
    @(posedge clk);
    #2;
    s     = 4'h7;
    reset = 1'b1;
    #1;
    chk("rel_before_edge", seg_q_al, 7'b1111111);
    @(posedge clk);
    #1;
    chk("rel_after_edge", seg_q_al, 7'b1111000);

    // Sweep every code; seg is checked 1 ns after each change.
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #2;
      s = 4'(i);
      #1;
      chk("sweep_seg_al", seg_al, model(s, 1'b1));
      chk("sweep_seg_ah", seg_ah, model(s, 1'b0));
      if (i == 0)  chk("lit_s0", seg_al, 7'b1000000);
      if (i == 8)  chk("lit_s8", seg_al, 7'b0000000);
      if (i == 15) chk("lit_sF", seg_al, 7'b0001110);
      if (i == 11) chk("lit_sb", seg_al, 7'b0000011);
    end

    // Mid-cycle change 1 -> 2: seg follows at once, seg_q waits for the edge.
    @(posedge clk);
    #2;
    s = 4'h1;
    @(posedge clk);
    #1;
    chk("mid_q_before", seg_q_al, 7'b1111001);
    #6;
    s = 4'h2;
    #1;
    chk("mid_seg", seg_al, 7'b0100100);
    chk("mid_q_hold", seg_q_al, 7'b1111001);
    @(posedge clk);
    #1;
    chk("mid_q_after", seg_q_al, 7'b0100100);

    // Reset asserted mid-stream between edges: immediate blank, decoder unaffected.
    #1;
    s = 4'h8;
    @(posedge clk);
    #1;
    chk("pre_rst_q", seg_q_al, 7'b0000000);
    #6;
    reset = 1'b0;
    #1;
    chk("async_rst_q",    seg_q_al, 7'b1111111);
    chk("async_rst_q_ah", seg_q_ah, 7'b0000000);
    chk("async_rst_seg",  seg_al,   7'b0000000);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;

    // Inverted polarity build with s=0.
    @(posedge clk);
    #2;
    s = 4'h0;
    #1;
    chk("ah_seg_s0", seg_ah, 7'b0111111);
    @(posedge clk);
    #1;
    chk("ah_q_s0", seg_q_ah, 7'b0111111);

    // A short run of random codes, checked by the continuous compare.
    for (int i = 0; i < 24; i++) begin
      @(posedge clk);
      #2;
      s = 4'($urandom_range(0, 15));
    end

    repeat (2) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
